// File: rtl/axis_frame_stats_pkg.sv
// Shared types and helpers for the AXI-Stream frame statistics monitor.
// Optional min/max tracking is enabled by defining AXIS_FRAME_STATS_MINMAX_EN.
package axis_frame_stats_pkg;

  // Widest supported frame length and tkeep; narrower instances cast into these.
  localparam int LEN_MAX_W  = 32;
  localparam int KEEP_MAX_W = 128;

  // One completed-frame result: length and "length saturated" flag.
  typedef struct packed {
    logic                 sat;
    logic [LEN_MAX_W-1:0] len;
  } len_rec_t;

  // Number of set bits in a byte-enable mask; gaps in the mask are counted as-is.
  function automatic logic [7:0] popcount(input logic [KEEP_MAX_W-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_frame_stats_fifo.sv
// Result FIFO for axis_frame_stats. Shift-register organisation so the head
// entry is always a flop (registered output); output reads as zero when empty.
module axis_frame_stats_fifo
  import axis_frame_stats_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  len_rec_t push_data,
  input  logic     pop,
  output logic     full,
  output logic     out_valid,
  output len_rec_t out_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  len_rec_t           mem_q [DEPTH];
  len_rec_t           mem_d [DEPTH];
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   wr_pos;
  logic               do_pop;
  logic               do_push;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem_q[0] : '0;

  // Next-state: shift down on pop, then write behind the last occupied slot.
  always_comb begin
    mem_d   = mem_q;
    do_pop  = pop && out_valid;
    do_push = push && (!full || do_pop);
    wr_pos  = do_pop ? (cnt_q - CNT_W'(1)) : cnt_q;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i + 1];
      end
      mem_d[DEPTH-1] = '0;
    end
    if (do_push) begin
      mem_d[wr_pos[IDX_W-1:0]] = push_data;
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Occupancy is control state and is reset; storage is data and is not.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Storage update.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axis_frame_stats.sv
// Passive AXI-Stream frame length monitor: accumulates accepted bytes (or
// beats) per frame, queues each completed length in a small FIFO and keeps
// frame/drop counters. Define AXIS_FRAME_STATS_MINMAX_EN to also track the
// shortest and longest completed frame.
module axis_frame_stats
  import axis_frame_stats_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEEP_WIDTH-1:0] monitor_axis_tkeep,
  input  logic                  monitor_axis_tvalid,
  input  logic                  monitor_axis_tready,
  input  logic                  monitor_axis_tlast,
  input  logic                  stat_clear,
  output logic [LEN_WIDTH-1:0]  len_tdata,
  output logic                  len_tuser,
  output logic                  len_tvalid,
  input  logic                  len_tready,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic [LEN_WIDTH-1:0]  min_len,
  output logic [LEN_WIDTH-1:0]  max_len
);

  localparam int SUM_W = LEN_WIDTH + 9;
  localparam logic [LEN_WIDTH-1:0] LEN_ONES = {LEN_WIDTH{1'b1}};

  // Saturating add of a beat count into the length; returns {overflow, len}.
  function automatic logic [LEN_WIDTH:0] len_add(input logic [LEN_WIDTH-1:0] acc,
                                                 input logic [7:0] cnt);
    logic [SUM_W-1:0] s;
    s = SUM_W'(acc) + SUM_W'(cnt);
    if (s > SUM_W'(LEN_ONES)) begin
      return {1'b1, LEN_ONES};
    end
    return {1'b0, s[LEN_WIDTH-1:0]};
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [LEN_WIDTH-1:0] acc_q, acc_d;
  logic                 sat_q, sat_d;
  logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic [7:0]           beat_cnt;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 ovf;
  logic [LEN_WIDTH-1:0] new_len;
  logic                 new_sat;
  logic                 fifo_full;
  len_rec_t             push_rec;
  len_rec_t             out_rec;

  // Per-beat accounting and the result record for a closing beat.
  always_comb begin
    accept         = monitor_axis_tvalid && monitor_axis_tready;
    push           = accept && monitor_axis_tlast;
    beat_cnt       = KEEP_ENABLE ? popcount(KEEP_MAX_W'(monitor_axis_tkeep)) : 8'd1;
    {ovf, new_len} = len_add(acc_q, beat_cnt);
    new_sat        = sat_q | ovf;
    push_rec.len   = LEN_MAX_W'(new_len);
    push_rec.sat   = new_sat;
    acc_d          = acc_q;
    sat_d          = sat_q;
    if (accept) begin
      if (monitor_axis_tlast) begin
        acc_d = '0;
        sat_d = 1'b0;
      end else begin
        acc_d = new_len;
        sat_d = new_sat;
      end
    end
  end

  // Counter next-state; a clear coinciding with a frame end counts that frame.
  always_comb begin
    pop  = len_tvalid && len_tready;
    drop = push && fifo_full && !pop;
    if (stat_clear) begin
      frame_count_d = push ? CNT_WIDTH'(1) : '0;
      drop_count_d  = drop ? CNT_WIDTH'(1) : '0;
    end else begin
      frame_count_d = frame_count_q + CNT_WIDTH'(push);
      drop_count_d  = drop ? sat_inc(drop_count_q) : drop_count_q;
    end
  end

  // Accumulator and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= '0;
      sat_q         <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  axis_frame_stats_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .full      (fifo_full),
    .out_valid (len_tvalid),
    .out_data  (out_rec)
  );

  assign len_tdata   = LEN_WIDTH'(out_rec.len);
  assign len_tuser   = out_rec.sat;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;

`ifdef AXIS_FRAME_STATS_MINMAX_EN
  logic [LEN_WIDTH-1:0] min_len_q, min_len_d;
  logic [LEN_WIDTH-1:0] max_len_q, max_len_d;

  // Extremes over completed frames, including ones the FIFO dropped.
  always_comb begin
    min_len_d = min_len_q;
    max_len_d = max_len_q;
    if (stat_clear) begin
      min_len_d = push ? new_len : LEN_ONES;
      max_len_d = push ? new_len : '0;
    end else if (push) begin
      if (new_len < min_len_q) min_len_d = new_len;
      if (new_len > max_len_q) max_len_d = new_len;
    end
  end

  // Min/max registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_len_q <= LEN_ONES;
      max_len_q <= '0;
    end else begin
      min_len_q <= min_len_d;
      max_len_q <= max_len_d;
    end
  end

  assign min_len = min_len_q;
  assign max_len = max_len_q;
`else
  assign min_len = '0;
  assign max_len = '0;
`endif

endmodule

// File: tb/tb_axis_frame_stats.sv
// Directed bench for axis_frame_stats (64-bit bus, LEN_WIDTH=8, FIFO_DEPTH=4).
// Min/max expectations follow AXIS_FRAME_STATS_MINMAX_EN.
module tb_axis_frame_stats;

`ifdef AXIS_FRAME_STATS_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        stat_clear;
  logic [7:0]  len_tdata;
  logic        len_tuser;
  logic        len_tvalid;
  logic        len_tready;
  logic [31:0] frame_count;
  logic [31:0] drop_count;
  logic [7:0]  min_len;
  logic [7:0]  max_len;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  axis_frame_stats #(
    .DATA_WIDTH (64),
    .LEN_WIDTH  (8),
    .CNT_WIDTH  (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .monitor_axis_tkeep  (tkeep),
    .monitor_axis_tvalid (tvalid),
    .monitor_axis_tready (tready),
    .monitor_axis_tlast  (tlast),
    .stat_clear          (stat_clear),
    .len_tdata           (len_tdata),
    .len_tuser           (len_tuser),
    .len_tvalid          (len_tvalid),
    .len_tready          (len_tready),
    .frame_count         (frame_count),
    .drop_count          (drop_count),
    .min_len             (min_len),
    .max_len             (max_len)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] mm(input logic [31:0] v);
    return MM ? v : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tvalid = 1'b0;
    tready = 1'b0;
    tlast  = 1'b0;
    tkeep  = 8'h00;
  endtask

  task automatic beat(input logic [7:0] keep, input logic last);
    tvalid = 1'b1;
    tready = 1'b1;
    tkeep  = keep;
    tlast  = last;
    step();
    idle();
  endtask

  task automatic pop_one();
    len_tready = 1'b1;
    step();
    len_tready = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] len, input logic [31:0] user);
    chk({tag, "_vld"}, 32'(len_tvalid), 32'd1);
    chk({tag, "_len"}, 32'(len_tdata), len);
    chk({tag, "_user"}, 32'(len_tuser), user);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stat_clear = 1'b0; len_tready = 1'b0;
    idle();
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_vld", 32'(len_tvalid), 32'd0);
    chk("rst_len", 32'(len_tdata), 32'd0);
    chk("rst_user", 32'(len_tuser), 32'd0);
    chk("rst_fc", frame_count, 32'd0);
    chk("rst_dc", drop_count, 32'd0);
    chk("rst_min", 32'(min_len), mm(255));
    chk("rst_max", 32'(max_len), 32'd0);

    // 3 beats FF, FF, 0F -> 20, visible one cycle after the last beat
    beat(8'hFF, 1'b0);
    beat(8'hFF, 1'b0);
    tvalid = 1'b1; tready = 1'b1; tkeep = 8'h0F; tlast = 1'b1;
    chk("lat_pre_vld", 32'(len_tvalid), 32'd0);
    step(); idle();
    chk_out("f20", 20, 0);
    chk("f20_fc", frame_count, 32'd1);
    chk("f20_min", 32'(min_len), mm(20));
    pop_one();
    chk("f20_popped", 32'(len_tvalid), 32'd0);
    chk("f20_empty_len", 32'(len_tdata), 32'd0);

    // tkeep 00 single beat -> 0
    beat(8'h00, 1'b1);
    chk_out("f0", 0, 0);
    chk("f0_fc", frame_count, 32'd2);
    chk("f0_min", 32'(min_len), mm(0));
    chk("f0_max", 32'(max_len), mm(20));
    pop_one();

    // Non-contiguous mask A5 -> 4
    beat(8'hA5, 1'b1);
    chk_out("fA5", 4, 0);
    pop_one();

    // 40 beats of FF saturate an 8-bit length
    for (int i = 0; i < 39; i++) beat(8'hFF, 1'b0);
    beat(8'hFF, 1'b1);
    chk_out("fsat", 255, 1);
    chk("fsat_max", 32'(max_len), mm(255));
    pop_one();
    beat(8'hFF, 1'b1);
    chk_out("fpost", 8, 0);
    chk("fpost_fc", frame_count, 32'd5);
    pop_one();

    // Clear without a frame end
    stat_clear = 1'b1; step(); stat_clear = 1'b0;
    chk("clr_fc", frame_count, 32'd0);
    chk("clr_dc", drop_count, 32'd0);
    chk("clr_min", 32'(min_len), mm(255));
    chk("clr_max", 32'(max_len), 32'd0);

    // Six frames into a 4-deep FIFO with no reader -> two drops
    beat(8'h01, 1'b1);
    beat(8'h03, 1'b1);
    beat(8'h07, 1'b1);
    beat(8'h0F, 1'b1);
    beat(8'h1F, 1'b1);
    beat(8'h3F, 1'b1);
    chk("ovf_fc", frame_count, 32'd6);
    chk("ovf_dc", drop_count, 32'd2);
    chk("ovf_min", 32'(min_len), mm(1));
    chk("ovf_max", 32'(max_len), mm(6));
    chk_out("ovf_head", 1, 0);
    step();
    chk_out("ovf_hold", 1, 0);

    // Push while full with a same-cycle pop is accepted
    len_tready = 1'b1;
    beat(8'hFF, 1'b1);
    len_tready = 1'b0;
    chk("pp_dc", drop_count, 32'd2);
    chk("pp_fc", frame_count, 32'd7);
    chk_out("drain0", 2, 0);
    pop_one();
    chk_out("drain1", 3, 0);
    pop_one();
    chk_out("drain2", 4, 0);
    pop_one();
    chk_out("drain3", 8, 0);
    pop_one();
    chk("drain_empty", 32'(len_tvalid), 32'd0);

    // Clear coinciding with the end of a 5-byte frame
    beat(8'h07, 1'b0);
    stat_clear = 1'b1;
    beat(8'h03, 1'b1);
    stat_clear = 1'b0;
    chk("cl5_fc", frame_count, 32'd1);
    chk("cl5_dc", drop_count, 32'd0);
    chk("cl5_min", 32'(min_len), mm(5));
    chk("cl5_max", 32'(max_len), mm(5));
    chk_out("cl5", 5, 0);
    pop_one();

    // Reset mid-frame discards the partial frame
    beat(8'hFF, 1'b0);
    beat(8'hFF, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_fc", frame_count, 32'd0);
    tvalid = 1'b1; tready = 1'b0; tkeep = 8'hFF; tlast = 1'b1;
    step(); idle();
    chk("noacc_vld", 32'(len_tvalid), 32'd0);
    chk("noacc_fc", frame_count, 32'd0);
    beat(8'h01, 1'b1);
    chk_out("mid_rst", 1, 0);
    chk("mid_rst_fc2", frame_count, 32'd1);
    pop_one();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
